router_out_arbiter: RTL and testbench

- Round-robin packet scheduler that shares one router output byte port between three per-channel packet FIFOs.
- Grants one channel and streams a whole packet before re-arbitrating: header, then `len` payload bytes, then parity.
- Checks the packet's running XOR parity and aborts stalled packets after a timeout.
- Sits between the router's channel FIFOs and the shared uo_out/uio output path inside tt_um_example.

---
 rtl/router_pkg.sv | 23 ++
 rtl/rr_arb3.sv | 30 +++
 rtl/router_out_arbiter.sv | 160 ++++++++++++++++
 tb/tb_router_out_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router output path: header field positions,
// scheduler FSM states and the round-robin channel successor.
package router_pkg;

  localparam int NUM_CH       = 3;
  localparam int HDR_LEN_MSB  = 5;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_DEST_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    PAR
  } state_e;

  // Next channel in ring order; index 3 is never a real channel and folds to 0.
  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c >= 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational three-way round-robin picker; the search starts at the
// channel after the last one granted.
module rr_arb3
  import router_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last,
  output logic [1:0]        gnt_idx,
  output logic              any_req
);

  logic [1:0] cand0, cand1, cand2;

  assign cand0   = next_ch(last);
  assign cand1   = next_ch(cand0);
  assign cand2   = next_ch(cand1);
  assign any_req = |req;

  always_comb begin
    gnt_idx = 2'd0;
    if (req[cand0]) begin
      gnt_idx = cand0;
    end else if (req[cand1]) begin
      gnt_idx = cand1;
    end else if (req[cand2]) begin
      gnt_idx = cand2;
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Shares one output byte port between three channel FIFOs, forwarding whole
// header/payload/parity packets with parity checking and stall timeout.
module router_out_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ch_empty,
  input  logic [8*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]   ch_rd_en,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_ch,
  output logic                out_sop,
  output logic                out_eop,
  output logic                busy,
  output logic                parity_err,
  output logic                timeout_err
);
  import router_pkg::*;

  localparam int STALL_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [1:0]           ch_q, ch_d;
  logic [1:0]           last_q, last_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           acc_q, acc_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 perr_q, perr_d;
  logic                 terr_q, terr_d;

  logic [7:0]           data_mux;
  logic                 gnt_empty;
  logic                 xfer;
  logic                 stall_expired;
  logic [1:0]           gnt_idx;
  logic                 any_req;

  rr_arb3 u_rr (
    .req     (~ch_empty),
    .last    (last_q),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  always_comb begin
    data_mux  = ch_data[7:0];
    gnt_empty = ch_empty[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (ch_q == 2'(i)) begin
        data_mux  = ch_data[i*8 +: 8];
        gnt_empty = ch_empty[i];
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = busy && !gnt_empty;
  assign xfer      = out_valid && out_ready;
  assign out_data  = data_mux;
  assign out_ch    = ch_q;
  assign out_sop   = (state_q == HDR);
  assign out_eop   = (state_q == PAR);
  assign parity_err  = perr_q;
  assign timeout_err = terr_q;

  // A stalled cycle only counts while downstream is willing to take data.
  assign stall_expired = busy && gnt_empty && out_ready &&
                         (stall_q == STALL_W'(TIMEOUT - 1));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rd
    assign ch_rd_en[gi] = xfer && (ch_q == 2'(gi));
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    stall_d = stall_q;
    perr_d  = 1'b0;
    terr_d  = 1'b0;

    if (busy) begin
      if (!gnt_empty) begin
        stall_d = '0;
      end else if (out_ready) begin
        stall_d = stall_q + STALL_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (any_req) begin
          ch_d    = gnt_idx;
          last_d  = gnt_idx;
          stall_d = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          acc_d = data_mux;
          cnt_d = data_mux[HDR_LEN_MSB:HDR_LEN_LSB];
          state_d = (data_mux[HDR_LEN_MSB:HDR_LEN_LSB] == 4'd0) ? PAR : PAY;
        end
      end
      PAY: begin
        if (xfer) begin
          acc_d = acc_q ^ data_mux;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = PAR;
          end
        end
      end
      PAR: begin
        if (xfer) begin
          perr_d  = ((acc_q ^ data_mux) != 8'h00);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abandon the packet; leftover FIFO bytes will be read as a fresh header.
    if (stall_expired) begin
      terr_d  = 1'b1;
      stall_d = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= 4'd0;
      acc_q   <= 8'h00;
      stall_q <= '0;
      perr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      stall_q <= stall_d;
      perr_q  <= perr_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: bench-side FIFO models, a per-cycle
// vector table and hand-written sequences for arbitration, stall and reset.
module tb_router_out_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ch_empty;
  logic [23:0] ch_data;
  logic [2:0]  ch_rd_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic        out_sop;
  logic        out_eop;
  logic        busy;
  logic        parity_err;
  logic        timeout_err;

  router_out_arbiter #(.NUM_CH(3), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_empty    (ch_empty),
    .ch_data     (ch_data),
    .ch_rd_en    (ch_rd_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .busy        (busy),
    .parity_err  (parity_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit         load;
    bit         rdy;
    bit         v;
    logic [7:0] d;
    bit         sop;
    bit         eop;
    logic [2:0] rd;
    bit         busy;
    bit         perr;
    bit         terr;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] head(input int c);
    case (c)
      0: return (q0.size() > 0) ? q0[0] : 8'h00;
      1: return (q1.size() > 0) ? q1[0] : 8'h00;
      default: return (q2.size() > 0) ? q2[0] : 8'h00;
    endcase
  endfunction

  task automatic drive_fifo();
    ch_empty[0]     = (q0.size() == 0);
    ch_empty[1]     = (q1.size() == 0);
    ch_empty[2]     = (q2.size() == 0);
    ch_data[7:0]    = head(0);
    ch_data[15:8]   = head(1);
    ch_data[23:16]  = head(2);
  endtask

  task automatic push(input int c, input logic [7:0] b);
    case (c)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic pop(input int c);
    case (c)
      0: if (q0.size() > 0) void'(q0.pop_front());
      1: if (q1.size() > 0) void'(q1.pop_front());
      default: if (q2.size() > 0) void'(q2.pop_front());
    endcase
  endtask

  // Bytes are listed most-significant first: first byte on the wire is byte n-1.
  task automatic load(input int c, input int n, input logic [63:0] bytes_v);
    for (int i = n - 1; i >= 0; i--) push(c, bytes_v[i*8 +: 8]);
    drive_fifo();
  endtask

  task automatic tick();
    logic [2:0] rd;
    rd = ch_rd_en;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      if (rd[c]) begin
        $display("xfer ch%0d byte %02h", c, head(c));
        pop(c);
      end
    end
    drive_fifo();
    #1;
  endtask

  // Starts at an IDLE sample point with this channel about to win arbitration.
  task automatic run_pkt(input int c, input int n, input logic [63:0] bytes_v, input bit perr);
    tick();
    for (int i = 0; i < n; i++) begin
      logic [7:0] eb;
      eb = bytes_v[(n-1-i)*8 +: 8];
      chk($sformatf("pkt ch%0d b%0d valid", c, i), out_valid, 1);
      chk($sformatf("pkt ch%0d b%0d out_ch", c, i), out_ch, c);
      chk($sformatf("pkt ch%0d b%0d data", c, i), out_data, eb);
      chk($sformatf("pkt ch%0d b%0d sop", c, i), out_sop, (i == 0));
      chk($sformatf("pkt ch%0d b%0d eop", c, i), out_eop, (i == n - 1));
      chk($sformatf("pkt ch%0d b%0d rd_en", c, i), ch_rd_en, 3'b001 << c);
      tick();
    end
    chk($sformatf("pkt ch%0d end busy", c), busy, 0);
    chk($sformatf("pkt ch%0d parity_err", c), parity_err, perr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_en"}, ch_rd_en, 0);
    chk({tag, " valid"}, out_valid, 0);
    chk({tag, " sop"}, out_sop, 0);
    chk({tag, " eop"}, out_eop, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " parity_err"}, parity_err, 0);
    chk({tag, " timeout_err"}, timeout_err, 0);
    chk({tag, " out_ch"}, out_ch, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive_fifo();

    vt[0]  = '{1, 1, 0, 8'h00, 0, 0, 3'b000, 0, 0, 0};
    vt[1]  = '{0, 1, 1, 8'h08, 1, 0, 3'b001, 1, 0, 0};
    vt[2]  = '{0, 1, 1, 8'hA0, 0, 0, 3'b001, 1, 0, 0};
    vt[3]  = '{0, 1, 1, 8'hA1, 0, 0, 3'b001, 1, 0, 0};
    vt[4]  = '{0, 1, 1, 8'h09, 0, 1, 3'b001, 1, 0, 0};
    vt[5]  = '{0, 1, 0, 8'h00, 0, 0, 3'b000, 0, 0, 0};
    vt[6]  = '{1, 1, 0, 8'h00, 0, 0, 3'b000, 0, 0, 0};
    vt[7]  = '{0, 1, 1, 8'h08, 1, 0, 3'b001, 1, 0, 0};
    vt[8]  = '{0, 0, 1, 8'hA0, 0, 0, 3'b000, 1, 0, 0};
    vt[9]  = '{0, 0, 1, 8'hA0, 0, 0, 3'b000, 1, 0, 0};
    vt[10] = '{0, 0, 1, 8'hA0, 0, 0, 3'b000, 1, 0, 0};
    vt[11] = '{0, 1, 1, 8'hA0, 0, 0, 3'b001, 1, 0, 0};
    vt[12] = '{0, 1, 1, 8'hA1, 0, 0, 3'b001, 1, 0, 0};
    vt[13] = '{0, 1, 1, 8'h09, 0, 1, 3'b001, 1, 0, 0};
    vt[14] = '{0, 1, 0, 8'h00, 0, 0, 3'b000, 0, 0, 0};

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("post-reset busy", busy, 0);

    // ch0 and ch1 together: ch0 first (last_grant resets to 2); ch1 packet has bad parity
    load(0, 4, 64'h08A0A109);
    load(1, 3, 64'h05A4A0);
    run_pkt(0, 4, 64'h08A0A109, 0);
    run_pkt(1, 3, 64'h05A4A0, 1);

    // All three loaded after last_grant=1: order ch2, ch0, ch1
    load(0, 3, 64'h041115);
    load(1, 4, 64'h09223318);
    load(2, 2, 64'h0202);
    run_pkt(2, 2, 64'h0202, 0);
    run_pkt(0, 3, 64'h041115, 0);
    run_pkt(1, 4, 64'h09223318, 0);

    // Table: clean ch0 packet, then the same packet with 3 cycles of backpressure
    for (int r = 0; r < 15; r++) begin
      if (vt[r].load) load(0, 4, 64'h08A0A109);
      out_ready = vt[r].rdy;
      #1;
      chk($sformatf("vec%0d valid", r), out_valid, vt[r].v);
      if (vt[r].v) chk($sformatf("vec%0d data", r), out_data, vt[r].d);
      if (vt[r].v) chk($sformatf("vec%0d out_ch", r), out_ch, 0);
      chk($sformatf("vec%0d sop", r), out_sop, vt[r].sop);
      chk($sformatf("vec%0d eop", r), out_eop, vt[r].eop);
      chk($sformatf("vec%0d rd_en", r), ch_rd_en, vt[r].rd);
      chk($sformatf("vec%0d busy", r), busy, vt[r].busy);
      chk($sformatf("vec%0d parity_err", r), parity_err, vt[r].perr);
      chk($sformatf("vec%0d timeout_err", r), timeout_err, vt[r].terr);
      tick();
    end
    out_ready = 1'b1;
    #1;

    // ch2 packet with wrong parity byte: forwarded, one-cycle parity_err
    load(2, 5, 64'h0EB0B1B200);
    run_pkt(2, 5, 64'h0EB0B1B200, 1);
    tick();
    chk("perr one-cycle", parity_err, 0);

    // ch1 header then empty: timeout after 16 stalled cycles, then ch2 granted
    load(1, 1, 64'h0C);
    load(2, 3, 64'h04C0C4);
    tick();
    chk("to hdr out_ch", out_ch, 1);
    chk("to hdr data", out_data, 8'h0C);
    chk("to hdr sop", out_sop, 1);
    chk("to hdr rd_en", ch_rd_en, 3'b010);
    tick();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("stall%0d busy", k), busy, 1);
      chk($sformatf("stall%0d valid", k), out_valid, 0);
      chk($sformatf("stall%0d rd_en", k), ch_rd_en, 0);
      chk($sformatf("stall%0d timeout_err", k), timeout_err, 0);
      tick();
    end
    chk("timeout pulse", timeout_err, 1);
    chk("timeout busy", busy, 0);
    tick();
    chk("after timeout pulse", timeout_err, 0);
    chk("after timeout busy", busy, 1);
    chk("after timeout out_ch", out_ch, 2);
    chk("after timeout data", out_data, 8'h04);
    chk("after timeout sop", out_sop, 1);
    tick();
    tick();
    tick();
    chk("ch2 after timeout done busy", busy, 0);
    chk("ch2 after timeout parity_err", parity_err, 0);

    // Asynchronous reset in the middle of a ch1 payload
    load(1, 4, 64'h08A0A109);
    tick();
    chk("pre-rst out_ch", out_ch, 1);
    tick();
    chk("pre-rst busy", busy, 1);
    chk("pre-rst data", out_data, 8'hA0);
    load(0, 3, 64'h041115);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    chk("async rst data ch0 slice", out_data, 8'h04);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst release busy", busy, 0);
    tick();
    chk("first grant after rst out_ch", out_ch, 0);
    chk("first grant after rst sop", out_sop, 1);
    chk("first grant after rst data", out_data, 8'h04);
    chk("first grant after rst busy", busy, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
